// File: rtl/tunnel_map_pkg.sv
// tunnel_map_pkg: shared definitions for the tunnel occupancy map.
//   state_t          - load/run sequencer states
//   DEF_GRID_W/H     - default playfield dimensions in tiles
//   tile_x_t/tile_y_t - tile coordinate types for the default grid
package tunnel_map_pkg;

   localparam int DEF_GRID_W = 32;
   localparam int DEF_GRID_H = 24;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SEED,
      DONE,
      RUN
   } state_t;

   typedef logic [$clog2(DEF_GRID_W)-1:0] tile_x_t;
   typedef logic [$clog2(DEF_GRID_H)-1:0] tile_y_t;

endpackage

// File: rtl/tunnel_seed_walker.sv
// tunnel_seed_walker: steps through the seed segments one tile per cycle.
//   Clk, Reset_n   - clock, synchronous active-low reset
//   start          - pulse on the last clear cycle; first tile is presented next cycle
//   seg_*          - latched segment descriptors (position, length, orientation)
//   any_seg        - at least one segment has nonzero length
//   valid          - tile_x/tile_y/in_range describe a tile this cycle
//   in_range       - tile lies on the grid (otherwise the cycle is spent without a write)
//   last           - this is the final tile of the whole seed pass
module tunnel_seed_walker
   import tunnel_map_pkg::*;
#(
   parameter int GRID_W   = DEF_GRID_W,
   parameter int GRID_H   = DEF_GRID_H,
   parameter int NUM_SEGS = 4,
   parameter int LEN_W    = 4,
   parameter int XW       = $clog2(GRID_W),
   parameter int YW       = $clog2(GRID_H)
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic                      start,
   input  logic [NUM_SEGS*XW-1:0]    seg_x,
   input  logic [NUM_SEGS*YW-1:0]    seg_y,
   input  logic [NUM_SEGS*LEN_W-1:0] seg_len,
   input  logic [NUM_SEGS-1:0]       seg_vert,
   output logic                      any_seg,
   output logic                      valid,
   output logic                      in_range,
   output logic                      last,
   output logic [XW-1:0]             tile_x,
   output logic [YW-1:0]             tile_y
);

   localparam int IW = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
   // Wide enough that start + offset never wraps, so off-grid tiles are detected.
   localparam int SW = ((XW > YW) ? XW : YW) + LEN_W + 1;

   logic              active;
   logic [IW-1:0]     idx;
   logic [LEN_W-1:0]  k;
   logic [NUM_SEGS-1:0] nz;
   logic [IW-1:0]     first_idx;
   logic [IW-1:0]     next_idx;
   logic              found_first;
   logic              has_next;
   logic [LEN_W-1:0]  cur_len;
   logic [SW-1:0]     sx;
   logic [SW-1:0]     sy;
   logic              seg_end;

   // Zero-length segments are skipped entirely by jumping to the next nonzero one.
   always_comb begin
      nz          = '0;
      first_idx   = '0;
      next_idx    = '0;
      found_first = 1'b0;
      has_next    = 1'b0;
      for (int unsigned i = 0; i < NUM_SEGS; i++) begin
         nz[i] = (seg_len[i*LEN_W +: LEN_W] != '0);
         if (nz[i] && !found_first) begin
            first_idx   = IW'(i);
            found_first = 1'b1;
         end
         if (nz[i] && (32'(i) > 32'(idx)) && !has_next) begin
            next_idx = IW'(i);
            has_next = 1'b1;
         end
      end
   end

   always_comb begin
      cur_len = seg_len[idx*LEN_W +: LEN_W];
      sx      = SW'(seg_x[idx*XW +: XW]) + (seg_vert[idx] ? '0 : SW'(k));
      sy      = SW'(seg_y[idx*YW +: YW]) + (seg_vert[idx] ? SW'(k) : '0);
      seg_end = (k == cur_len - LEN_W'(1));
   end

   assign any_seg  = |nz;
   assign valid    = active;
   assign in_range = (32'(sx) < 32'(GRID_W)) && (32'(sy) < 32'(GRID_H));
   assign last     = active && seg_end && !has_next;
   assign tile_x   = sx[XW-1:0];
   assign tile_y   = sy[YW-1:0];

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         active <= 1'b0;
         idx    <= '0;
         k      <= '0;
      end else if (start) begin
         active <= any_seg;
         idx    <= first_idx;
         k      <= '0;
      end else if (active) begin
         if (seg_end) begin
            k <= '0;
            if (has_next) idx <= next_idx;
            else          active <= 1'b0;
         end else begin
            k <= k + LEN_W'(1);
         end
      end
   end

endmodule

// File: rtl/tunnel_map.sv
// tunnel_map: per-tile dug/undug map with clear+seed loader, dig port and read port.
//   Clk, Reset_n            - clock, synchronous active-low reset
//   load_req, seg_*         - start a level load with the given seed segments
//   busy, load_done         - loader status; load_done pulses once per completed load
//   dig_valid, dig_x, dig_y - player dig request; dig_new pulses if a fresh tile was dug
//   rd_x, rd_y, rd_dug      - registered read port (1-cycle latency)
//   dug_count               - number of dug tiles
module tunnel_map
   import tunnel_map_pkg::*;
#(
   parameter int GRID_W   = DEF_GRID_W,
   parameter int GRID_H   = DEF_GRID_H,
   parameter int NUM_SEGS = 4,
   parameter int LEN_W    = 4,
   parameter int XW       = $clog2(GRID_W),
   parameter int YW       = $clog2(GRID_H),
   parameter int CW       = $clog2(GRID_W*GRID_H+1)
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic                      load_req,
   input  logic [NUM_SEGS*XW-1:0]    seg_x,
   input  logic [NUM_SEGS*YW-1:0]    seg_y,
   input  logic [NUM_SEGS*LEN_W-1:0] seg_len,
   input  logic [NUM_SEGS-1:0]       seg_vert,
   output logic                      busy,
   output logic                      load_done,
   input  logic                      dig_valid,
   input  logic [XW-1:0]             dig_x,
   input  logic [YW-1:0]             dig_y,
   output logic                      dig_new,
   input  logic [XW-1:0]             rd_x,
   input  logic [YW-1:0]             rd_y,
   output logic                      rd_dug,
   output logic [CW-1:0]             dug_count
);

   logic [GRID_W-1:0]         map [GRID_H];
   state_t                    state;
   logic [YW-1:0]             row;
   logic [NUM_SEGS*XW-1:0]    lat_x;
   logic [NUM_SEGS*YW-1:0]    lat_y;
   logic [NUM_SEGS*LEN_W-1:0] lat_len;
   logic [NUM_SEGS-1:0]       lat_vert;

   logic          any_seg;
   logic          seed_valid;
   logic          seed_in_range;
   logic          seed_last;
   logic [XW-1:0] seed_x;
   logic [YW-1:0] seed_y;
   logic          clear_last;
   logic          rd_ok;
   logic          dig_ok;

   assign clear_last = (state == CLEAR) && (row == YW'(GRID_H-1));
   assign rd_ok      = (32'(rd_x) < 32'(GRID_W)) && (32'(rd_y) < 32'(GRID_H));
   assign dig_ok     = (32'(dig_x) < 32'(GRID_W)) && (32'(dig_y) < 32'(GRID_H));

   tunnel_seed_walker #(
      .GRID_W   (GRID_W),
      .GRID_H   (GRID_H),
      .NUM_SEGS (NUM_SEGS),
      .LEN_W    (LEN_W),
      .XW       (XW),
      .YW       (YW)
   ) u_walker (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .start    (clear_last),
      .seg_x    (lat_x),
      .seg_y    (lat_y),
      .seg_len  (lat_len),
      .seg_vert (lat_vert),
      .any_seg  (any_seg),
      .valid    (seed_valid),
      .in_range (seed_in_range),
      .last     (seed_last),
      .tile_x   (seed_x),
      .tile_y   (seed_y)
   );

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         for (int unsigned r = 0; r < GRID_H; r++) map[r] <= '0;
         state     <= IDLE;
         row       <= '0;
         busy      <= 1'b0;
         load_done <= 1'b0;
         dig_new   <= 1'b0;
         rd_dug    <= 1'b0;
         dug_count <= '0;
         lat_x     <= '0;
         lat_y     <= '0;
         lat_len   <= '0;
         lat_vert  <= '0;
      end else begin
         load_done <= 1'b0;
         dig_new   <= 1'b0;
         rd_dug    <= rd_ok ? map[rd_y][rd_x] : 1'b0;
         case (state)
            IDLE, RUN: begin
               // A load accepted on the same edge as a dig takes precedence.
               if (load_req) begin
                  lat_x     <= seg_x;
                  lat_y     <= seg_y;
                  lat_len   <= seg_len;
                  lat_vert  <= seg_vert;
                  row       <= '0;
                  dug_count <= '0;
                  busy      <= 1'b1;
                  state     <= CLEAR;
               end else if (dig_valid && dig_ok && !map[dig_y][dig_x]) begin
                  map[dig_y][dig_x] <= 1'b1;
                  dug_count         <= dug_count + CW'(1);
                  dig_new           <= 1'b1;
               end
            end
            CLEAR: begin
               map[row] <= '0;
               if (clear_last) begin
                  // With no nonzero segment the seed pass is empty: go straight to DONE.
                  state     <= any_seg ? SEED : DONE;
                  load_done <= !any_seg;
               end else begin
                  row <= row + YW'(1);
               end
            end
            SEED: begin
               if (seed_valid && seed_in_range && !map[seed_y][seed_x]) begin
                  map[seed_y][seed_x] <= 1'b1;
                  dug_count           <= dug_count + CW'(1);
               end
               if (seed_last || !seed_valid) begin
                  state     <= DONE;
                  load_done <= 1'b1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= RUN;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tunnel_map.sv
module tb_tunnel_map;
   localparam int GW = 32;
   localparam int GH = 24;
   localparam int NS = 4;
   localparam int LW = 4;
   localparam int XW = 5;
   localparam int YW = 5;
   localparam int CW = $clog2(GW*GH+1);

   logic             Clk = 1'b0;
   logic             Reset_n = 1'b0;
   logic             load_req = 1'b0;
   logic [NS*XW-1:0] seg_x = '0;
   logic [NS*YW-1:0] seg_y = '0;
   logic [NS*LW-1:0] seg_len = '0;
   logic [NS-1:0]    seg_vert = '0;
   logic             busy;
   logic             load_done;
   logic             dig_valid = 1'b0;
   logic [XW-1:0]    dig_x = '0;
   logic [YW-1:0]    dig_y = '0;
   logic             dig_new;
   logic [XW-1:0]    rd_x = '0;
   logic [YW-1:0]    rd_y = '0;
   logic             rd_dug;
   logic [CW-1:0]    dug_count;

   int checks = 0;
   int errors = 0;
   bit model [GH][GW];
   int sx [NS];
   int sy [NS];
   int sl [NS];
   int sv [NS];

   tunnel_map #(
      .GRID_W   (GW),
      .GRID_H   (GH),
      .NUM_SEGS (NS),
      .LEN_W    (LW)
   ) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .load_req  (load_req),
      .seg_x     (seg_x),
      .seg_y     (seg_y),
      .seg_len   (seg_len),
      .seg_vert  (seg_vert),
      .busy      (busy),
      .load_done (load_done),
      .dig_valid (dig_valid),
      .dig_x     (dig_x),
      .dig_y     (dig_y),
      .dig_new   (dig_new),
      .rd_x      (rd_x),
      .rd_y      (rd_y),
      .rd_dug    (rd_dug),
      .dug_count (dug_count)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model_count();
      int c = 0;
      for (int y = 0; y < GH; y++)
         for (int x = 0; x < GW; x++)
            c += int'(model[y][x]);
      return c;
   endfunction

   task automatic model_clear();
      for (int y = 0; y < GH; y++)
         for (int x = 0; x < GW; x++)
            model[y][x] = 1'b0;
   endtask

   // Reference: clear, then mark every on-grid tile of every segment.
   task automatic model_load();
      model_clear();
      for (int s = 0; s < NS; s++)
         for (int k = 0; k < sl[s]; k++) begin
            int x = sx[s] + ((sv[s] != 0) ? 0 : k);
            int y = sy[s] + ((sv[s] != 0) ? k : 0);
            if (x < GW && y < GH) model[y][x] = 1'b1;
         end
   endtask

   task automatic set_seg(input int s, input int x, input int y, input int len, input int vert);
      sx[s] = x; sy[s] = y; sl[s] = len; sv[s] = vert;
   endtask

   task automatic drive_segs();
      for (int i = 0; i < NS; i++) begin
         seg_x[i*XW +: XW]  = XW'(sx[i]);
         seg_y[i*YW +: YW]  = YW'(sy[i]);
         seg_len[i*LW +: LW] = LW'(sl[i]);
         seg_vert[i]        = (sv[i] != 0);
      end
   endtask

   // Issue a load, optionally re-request at cycle glitch_at and spray digs while busy.
   task automatic run_load(input string tag, input int glitch_at, input bit dig_busy);
      int n;
      int exp_lat;
      exp_lat = GH + 1;
      for (int i = 0; i < NS; i++) exp_lat += sl[i];
      drive_segs();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      seg_x = NS*XW'($urandom);
      seg_y = NS*YW'($urandom);
      seg_len = NS*LW'($urandom);
      seg_vert = NS'($urandom);
      model_load();
      n = 1;
      while (!load_done && n < exp_lat + 10) begin
         chk({tag, "_busy"}, 32'(busy), 1);
         load_req  = (n == glitch_at);
         dig_valid = dig_busy;
         dig_x     = XW'($urandom);
         dig_y     = YW'($urandom_range(0, GH-1));
         tick();
         n++;
      end
      load_req  = 1'b0;
      dig_valid = 1'b0;
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
      chk({tag, "_busy_done"}, 32'(busy), 1);
      tick();
      chk({tag, "_done_pulse"}, 32'(load_done), 0);
      chk({tag, "_busy_run"}, 32'(busy), 0);
      chk({tag, "_count"}, 32'(dug_count), 32'(model_count()));
   endtask

   task automatic check_map(input string tag);
      for (int y = 0; y < GH; y++)
         for (int x = 0; x < GW; x++) begin
            rd_x = XW'(x);
            rd_y = YW'(y);
            tick();
            chk($sformatf("%s_tile_%0d_%0d", tag, x, y), 32'(rd_dug), 32'(model[y][x]));
         end
      rd_x = 5'd3;
      rd_y = 5'd26;
      tick();
      chk({tag, "_rd_oob"}, 32'(rd_dug), 0);
   endtask

   task automatic do_dig(input int x, input int y);
      bit inr;
      bit old;
      inr = (x < GW) && (y < GH);
      old = inr ? model[y][x] : 1'b0;
      dig_valid = 1'b1;
      dig_x = XW'(x);
      dig_y = YW'(y);
      rd_x  = XW'(x);
      rd_y  = YW'(y);
      tick();
      dig_valid = 1'b0;
      if (inr) model[y][x] = 1'b1;
      chk($sformatf("dig_new_%0d_%0d", x, y), 32'(dig_new), 32'(inr && !old));
      chk($sformatf("dig_rd_old_%0d_%0d", x, y), 32'(rd_dug), 32'(old));
      chk($sformatf("dig_count_%0d_%0d", x, y), 32'(dug_count), 32'(model_count()));
      tick();
      chk($sformatf("dig_rd_new_%0d_%0d", x, y), 32'(rd_dug), inr ? 32'(model[y][x]) : 0);
      chk($sformatf("dig_new_drop_%0d_%0d", x, y), 32'(dig_new), 0);
   endtask

   initial begin
      int sum;
      int seen;
      int c0;

      // Reset state
      Reset_n = 1'b0;
      rd_x = 5'd3;
      rd_y = 5'd4;
      tick();
      tick();
      chk("rst_rd_dug", 32'(rd_dug), 0);
      chk("rst_count", 32'(dug_count), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_load_done", 32'(load_done), 0);
      chk("rst_dig_new", 32'(dig_new), 0);
      Reset_n = 1'b1;
      model_clear();
      tick();
      chk("idle_rd_3_4", 32'(rd_dug), 0);

      // Single vertical segment
      for (int i = 0; i < NS; i++) set_seg(i, 0, 0, 0, 0);
      set_seg(0, 2, 3, 5, 1);
      run_load("vert", 0, 1'b0);
      chk("vert_count5", 32'(dug_count), 5);
      check_map("vert");

      // Overlapping segments: shared tile counted once
      for (int i = 0; i < NS; i++) set_seg(i, 0, 0, 0, 0);
      set_seg(0, 5, 9, 3, 0);
      set_seg(1, 6, 7, 5, 1);
      run_load("overlap", 0, 1'b0);
      chk("overlap_count7", 32'(dug_count), 7);
      check_map("overlap");

      // Off-grid tiles skipped without wrap; digs while busy ignored
      for (int i = 0; i < NS; i++) set_seg(i, 0, 0, 0, 0);
      set_seg(0, 30, 0, 4, 0);
      run_load("offgrid", 0, 1'b1);
      chk("offgrid_count2", 32'(dug_count), 2);
      check_map("offgrid");

      // Digs in RUN
      do_dig(10, 10);
      do_dig(10, 10);
      do_dig(0, 25);
      for (int i = 0; i < 20; i++) do_dig($urandom_range(0, GW-1), $urandom_range(0, 31));
      check_map("digs");

      // All lengths zero
      for (int i = 0; i < NS; i++) set_seg(i, $urandom_range(0, 31), $urandom_range(0, 31), 0, 0);
      run_load("empty", 0, 1'b0);
      chk("empty_count0", 32'(dug_count), 0);

      // Randomized loads with an ignored re-request during the load
      for (int r = 0; r < 4; r++) begin
         sum = 0;
         for (int i = 0; i < NS; i++) begin
            set_seg(i, $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 15), $urandom_range(0, 1));
            sum += sl[i];
         end
         run_load($sformatf("rand%0d", r), GH + 1 + ((sum > 0) ? $urandom_range(0, sum-1) : 0), 1'b1);
         check_map($sformatf("rand%0d", r));
         for (int i = 0; i < 5; i++) do_dig($urandom_range(0, GW-1), $urandom_range(0, 31));
      end

      // Reset in the middle of seeding
      for (int i = 0; i < NS; i++) set_seg(i, 0, 0, 0, 0);
      set_seg(0, 0, 0, 15, 0);
      drive_segs();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      for (int i = 1; i < GH + 4; i++) tick();
      chk("midseed_busy", 32'(busy), 1);
      Reset_n = 1'b0;
      tick();
      Reset_n = 1'b1;
      model_clear();
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_load_done", 32'(load_done), 0);
      chk("midrst_count", 32'(dug_count), 0);
      chk("midrst_rd", 32'(rd_dug), 0);
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         seen += int'(load_done) + int'(busy);
      end
      chk("midrst_stays_idle", 32'(seen), 0);
      check_map("midrst");
      c0 = model_count();
      do_dig(3, 4);
      chk("idle_dig_count", 32'(dug_count), 32'(c0 + 1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
